// File: rtl/fu_wb_arbiter.sv
// Writeback arbiter: one result FIFO per functional-unit channel, drained onto
// NrWbPorts scoreboard writeback ports by round-robin or fixed-priority grant.
module fu_wb_arbiter #(
    parameter int NrFu        = 4,
    parameter int NrWbPorts   = 2,
    parameter int XLEN        = 64,
    parameter int TransIdBits = 3,
    parameter int FifoDepth   = 2,
    parameter int ArbMode     = 0
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   flush_i,
    input  logic [NrFu-1:0]                        fu_valid_i,
    output logic [NrFu-1:0]                        fu_ready_o,
    input  logic [NrFu-1:0][XLEN-1:0]              fu_result_i,
    input  logic [NrFu-1:0][TransIdBits-1:0]       fu_trans_id_i,
    input  logic [NrFu-1:0]                        fu_ex_valid_i,
    input  logic [NrFu-1:0][XLEN-1:0]              fu_ex_cause_i,
    output logic [NrWbPorts-1:0]                   wb_valid_o,
    output logic [NrWbPorts-1:0][XLEN-1:0]         wb_result_o,
    output logic [NrWbPorts-1:0][TransIdBits-1:0]  wb_trans_id_o,
    output logic [NrWbPorts-1:0]                   wb_ex_valid_o,
    output logic [NrWbPorts-1:0][XLEN-1:0]         wb_ex_cause_o,
    output logic                                   wb_conflict_o
);
    localparam int IdxW = $clog2(NrFu);
    localparam int CntW = $clog2(NrFu + 1);
    localparam int PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;

    typedef struct packed {
        logic [XLEN-1:0]        result;
        logic [TransIdBits-1:0] trans_id;
        logic                   ex_valid;
        logic [XLEN-1:0]        ex_cause;
    } entry_t;

    entry_t [NrFu-1:0] head;
    logic [NrFu-1:0]   empty;
    logic [NrFu-1:0]   full;
    logic [NrFu-1:0]   push;
    logic [NrFu-1:0]   pop;
    logic [NrFu-1:0]   grant;

    for (genvar i = 0; i < NrFu; i++) begin : g_fifo
        entry_t          mem [FifoDepth];
        logic [PtrW-1:0] rd_ptr;
        logic [PtrW-1:0] wr_ptr;
        logic [PtrW-1:0] rd_next;
        logic [PtrW-1:0] wr_next;
        logic            full_q;

        assign rd_next  = (rd_ptr == PtrW'(FifoDepth - 1)) ? '0 : rd_ptr + PtrW'(1);
        assign wr_next  = (wr_ptr == PtrW'(FifoDepth - 1)) ? '0 : wr_ptr + PtrW'(1);
        assign full[i]  = full_q;
        assign empty[i] = (rd_ptr == wr_ptr) && !full_q;
        assign head[i]  = mem[rd_ptr];
        // Ready depends on registered fullness only, so a full FIFO refuses even while popping.
        assign push[i]  = fu_valid_i[i] && !full_q && !flush_i;

        always_ff @(posedge clk_i) begin
            if (push[i]) begin
                mem[wr_ptr] <= entry_t'{fu_result_i[i], fu_trans_id_i[i],
                                        fu_ex_valid_i[i], fu_ex_cause_i[i]};
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                full_q <= 1'b0;
            end else if (flush_i) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                full_q <= 1'b0;
            end else begin
                if (push[i]) wr_ptr <= wr_next;
                if (pop[i])  rd_ptr <= rd_next;
                if (push[i] && !pop[i] && (wr_next == rd_ptr)) full_q <= 1'b1;
                else if (pop[i] && !push[i])                   full_q <= 1'b0;
            end
        end
    end

    assign fu_ready_o = ~full;

    logic [IdxW-1:0] rr_ptr;
    logic [IdxW-1:0] start;
    logic [IdxW:0]   idx_sum;
    logic [IdxW-1:0] idx;
    logic [IdxW-1:0] last_idx;
    logic [NrWbPorts-1:0] port_valid;
    logic [IdxW-1:0] port_sel [NrWbPorts];
    int              n_grant;

    // Walk channels from the start index, handing ports out in search order.
    always_comb begin
        grant      = '0;
        port_valid = '0;
        for (int p = 0; p < NrWbPorts; p++) port_sel[p] = '0;
        n_grant    = 0;
        last_idx   = '0;
        idx_sum    = '0;
        idx        = '0;
        start      = (ArbMode == 1) ? '0 : rr_ptr;
        for (int k = 0; k < NrFu; k++) begin
            idx_sum = {1'b0, start} + (IdxW + 1)'(k);
            if (idx_sum >= (IdxW + 1)'(NrFu)) idx_sum = idx_sum - (IdxW + 1)'(NrFu);
            idx = idx_sum[IdxW-1:0];
            if (!empty[idx] && (n_grant < NrWbPorts)) begin
                grant[idx] = 1'b1;
                for (int p = 0; p < NrWbPorts; p++) begin
                    if (p == n_grant) begin
                        port_valid[p] = 1'b1;
                        port_sel[p]   = idx;
                    end
                end
                n_grant  = n_grant + 1;
                last_idx = idx;
            end
        end
    end

    assign pop = flush_i ? '0 : grant;

    always_comb begin
        wb_valid_o    = '0;
        wb_result_o   = '0;
        wb_trans_id_o = '0;
        wb_ex_valid_o = '0;
        wb_ex_cause_o = '0;
        for (int p = 0; p < NrWbPorts; p++) begin
            if (port_valid[p] && !flush_i) begin
                wb_valid_o[p]    = 1'b1;
                wb_result_o[p]   = head[port_sel[p]].result;
                wb_trans_id_o[p] = head[port_sel[p]].trans_id;
                wb_ex_valid_o[p] = head[port_sel[p]].ex_valid;
                wb_ex_cause_o[p] = head[port_sel[p]].ex_cause;
            end
        end
    end

    logic [CntW-1:0] n_busy;

    always_comb begin
        n_busy = '0;
        for (int c = 0; c < NrFu; c++) n_busy = n_busy + CntW'(!empty[c]);
    end

    assign wb_conflict_o = (n_busy > CntW'(NrWbPorts));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr <= '0;
        end else if (flush_i) begin
            rr_ptr <= '0;
        end else if ((ArbMode == 0) && (|grant)) begin
            rr_ptr <= (last_idx == IdxW'(NrFu - 1)) ? '0 : last_idx + IdxW'(1);
        end
    end
endmodule

// File: tb/tb_fu_wb_arbiter.sv
// Bench for fu_wb_arbiter: a round-robin/2-port and a fixed-priority/1-port
// instance share stimulus and are both checked each cycle against a queue model.
module tb_fu_wb_arbiter;
    localparam int Depth = 2;

    logic clk;
    logic rst;
    logic flush;
    logic [3:0]        fu_valid;
    logic [3:0][63:0]  fu_result;
    logic [3:0][2:0]   fu_trans_id;
    logic [3:0]        fu_ex_valid;
    logic [3:0][63:0]  fu_ex_cause;

    logic [3:0]        rr_ready;
    logic [1:0]        rr_wb_valid;
    logic [1:0][63:0]  rr_wb_result;
    logic [1:0][2:0]   rr_wb_trans_id;
    logic [1:0]        rr_wb_ex_valid;
    logic [1:0][63:0]  rr_wb_ex_cause;
    logic              rr_conflict;

    logic [3:0]        fp_ready;
    logic [0:0]        fp_wb_valid;
    logic [0:0][63:0]  fp_wb_result;
    logic [0:0][2:0]   fp_wb_trans_id;
    logic [0:0]        fp_wb_ex_valid;
    logic [0:0][63:0]  fp_wb_ex_cause;
    logic              fp_conflict;

    fu_wb_arbiter #(.NrFu(4), .NrWbPorts(2), .XLEN(64), .TransIdBits(3),
                    .FifoDepth(Depth), .ArbMode(0)) dut_rr (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .fu_valid_i(fu_valid), .fu_ready_o(rr_ready), .fu_result_i(fu_result),
        .fu_trans_id_i(fu_trans_id), .fu_ex_valid_i(fu_ex_valid), .fu_ex_cause_i(fu_ex_cause),
        .wb_valid_o(rr_wb_valid), .wb_result_o(rr_wb_result), .wb_trans_id_o(rr_wb_trans_id),
        .wb_ex_valid_o(rr_wb_ex_valid), .wb_ex_cause_o(rr_wb_ex_cause), .wb_conflict_o(rr_conflict)
    );

    fu_wb_arbiter #(.NrFu(4), .NrWbPorts(1), .XLEN(64), .TransIdBits(3),
                    .FifoDepth(Depth), .ArbMode(1)) dut_fp (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .fu_valid_i(fu_valid), .fu_ready_o(fp_ready), .fu_result_i(fu_result),
        .fu_trans_id_i(fu_trans_id), .fu_ex_valid_i(fu_ex_valid), .fu_ex_cause_i(fu_ex_cause),
        .wb_valid_o(fp_wb_valid), .wb_result_o(fp_wb_result), .wb_trans_id_o(fp_wb_trans_id),
        .wb_ex_valid_o(fp_wb_ex_valid), .wb_ex_cause_o(fp_wb_ex_cause), .wb_conflict_o(fp_conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one queue per (instance, channel) plus a search pointer.
    typedef struct packed {
        logic [63:0] res;
        logic [2:0]  id;
        logic        exv;
        logic [63:0] cause;
    } ent_t;

    ent_t mq [8][$];
    int   mptr [2];
    int   g_ch [2][4];
    int   g_n  [2];
    int   g_busy [2];

    logic        got_v     [2][2];
    logic [63:0] got_res   [2][2];
    logic [2:0]  got_id    [2][2];
    logic        got_exv   [2][2];
    logic [63:0] got_cause [2][2];
    logic [3:0]  got_ready [2];
    logic        got_conf  [2];

    task automatic model_grant(input int m, input int np, input bit fixed);
        int start;
        start     = fixed ? 0 : mptr[m];
        g_n[m]    = 0;
        g_busy[m] = 0;
        for (int k = 0; k < 4; k++) begin
            int c;
            c = (start + k) % 4;
            if (mq[m*4+c].size() > 0) begin
                g_busy[m]++;
                if (g_n[m] < np) begin
                    g_ch[m][g_n[m]] = c;
                    g_n[m]++;
                end
            end
        end
    endtask

    task automatic model_check(input int m, input int np, input string tag);
        logic [3:0] rdy;
        ent_t       e;
        logic       ev;
        for (int c = 0; c < 4; c++) rdy[c] = (mq[m*4+c].size() < Depth);
        chk($sformatf("%s_ready", tag), 64'(got_ready[m]), 64'(rdy));
        chk($sformatf("%s_conflict", tag), 64'(got_conf[m]), 64'(g_busy[m] > np));
        for (int p = 0; p < np; p++) begin
            ev = !flush && (p < g_n[m]);
            e  = ev ? mq[m*4+g_ch[m][p]][0] : '0;
            chk($sformatf("%s_valid%0d", tag, p), 64'(got_v[m][p]), 64'(ev));
            chk($sformatf("%s_res%0d", tag, p), got_res[m][p], e.res);
            chk($sformatf("%s_id%0d", tag, p), 64'(got_id[m][p]), 64'(e.id));
            chk($sformatf("%s_exv%0d", tag, p), 64'(got_exv[m][p]), 64'(e.exv));
            chk($sformatf("%s_cause%0d", tag, p), got_cause[m][p], e.cause);
        end
    endtask

    task automatic model_update(input int m, input bit fixed);
        bit acc [4];
        if (flush) begin
            for (int c = 0; c < 4; c++) mq[m*4+c].delete();
            mptr[m] = 0;
            return;
        end
        for (int c = 0; c < 4; c++) acc[c] = fu_valid[c] && (mq[m*4+c].size() < Depth);
        for (int p = 0; p < g_n[m]; p++) void'(mq[m*4+g_ch[m][p]].pop_front());
        if (g_n[m] > 0 && !fixed) mptr[m] = (g_ch[m][g_n[m]-1] + 1) % 4;
        for (int c = 0; c < 4; c++)
            if (acc[c]) mq[m*4+c].push_back(ent_t'{fu_result[c], fu_trans_id[c],
                                                   fu_ex_valid[c], fu_ex_cause[c]});
    endtask

    always @(negedge clk) begin
        got_ready[0] = rr_ready;    got_conf[0] = rr_conflict;
        got_ready[1] = fp_ready;    got_conf[1] = fp_conflict;
        for (int p = 0; p < 2; p++) begin
            got_v[0][p]     = rr_wb_valid[p];
            got_res[0][p]   = rr_wb_result[p];
            got_id[0][p]    = rr_wb_trans_id[p];
            got_exv[0][p]   = rr_wb_ex_valid[p];
            got_cause[0][p] = rr_wb_ex_cause[p];
        end
        got_v[1][0]     = fp_wb_valid[0];
        got_res[1][0]   = fp_wb_result[0];
        got_id[1][0]    = fp_wb_trans_id[0];
        got_exv[1][0]   = fp_wb_ex_valid[0];
        got_cause[1][0] = fp_wb_ex_cause[0];
        if (rst) begin
            for (int i = 0; i < 8; i++) mq[i].delete();
            mptr[0] = 0;
            mptr[1] = 0;
        end
        model_grant(0, 2, 1'b0);
        model_grant(1, 1, 1'b1);
        model_check(0, 2, "rr");
        model_check(1, 1, "fp");
        if (!rst) begin
            model_update(0, 1'b0);
            model_update(1, 1'b1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int c, input logic [63:0] r, input logic [2:0] id,
                          input logic ev, input logic [63:0] cause);
        fu_valid[c]    = 1'b1;
        fu_result[c]   = r;
        fu_trans_id[c] = id;
        fu_ex_valid[c] = ev;
        fu_ex_cause[c] = cause;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        flush    = 1'b0;
        fu_valid = '0;
        @(negedge clk);
        chk("rst_rr_valid", 64'(rr_wb_valid), 64'h0);
        chk("rst_rr_ready", 64'(rr_ready), 64'hF);
        chk("rst_rr_conflict", 64'(rr_conflict), 64'h0);
        chk("rst_rr_res0", rr_wb_result[0], 64'h0);
        chk("rst_fp_valid", 64'(fp_wb_valid), 64'h0);
        chk("rst_fp_ready", 64'(fp_ready), 64'hF);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic [63:0] got_b [$];
    int          b_idx;
    bit          acc1;
    int          dens;

    initial begin
        rst         = 1'b1;
        flush       = 1'b0;
        fu_valid    = '0;
        fu_result   = '0;
        fu_trans_id = '0;
        fu_ex_valid = '0;
        fu_ex_cause = '0;

        // Single result, one-cycle latency.
        do_reset();
        set_ch(2, 64'hDEAD, 3'd5, 1'b0, 64'h0);
        tick();
        fu_valid = '0;
        @(negedge clk);
        chk("single_valid", 64'(rr_wb_valid), 64'h1);
        chk("single_res", rr_wb_result[0], 64'hDEAD);
        chk("single_id", 64'(rr_wb_trans_id[0]), 64'h5);
        tick();
        @(negedge clk);
        chk("single_drained", 64'(rr_wb_valid), 64'h0);
        tick();

        // All four channels at once, round-robin from pointer 0.
        do_reset();
        for (int c = 0; c < 4; c++) set_ch(c, 64'h100 + 64'(c), 3'(c), 1'b0, 64'h0);
        tick();
        fu_valid = '0;
        @(negedge clk);
        chk("conf_valid_a", 64'(rr_wb_valid), 64'h3);
        chk("conf_res0_a", rr_wb_result[0], 64'h100);
        chk("conf_res1_a", rr_wb_result[1], 64'h101);
        chk("conf_flag_a", 64'(rr_conflict), 64'h1);
        tick();
        @(negedge clk);
        chk("conf_res0_b", rr_wb_result[0], 64'h102);
        chk("conf_res1_b", rr_wb_result[1], 64'h103);
        chk("conf_flag_b", 64'(rr_conflict), 64'h0);
        tick();

        // Backpressure on ch1 of the fixed-priority instance while ch0 holds the port.
        do_reset();
        set_ch(0, 64'hA0, 3'd0, 1'b0, 64'h0);
        set_ch(1, 64'hB1, 3'd1, 1'b0, 64'h0);
        set_ch(2, 64'hC2, 3'd2, 1'b0, 64'h0);
        set_ch(3, 64'hD3, 3'd3, 1'b0, 64'h0);
        b_idx = 0;
        got_b.delete();
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (fp_wb_valid[0] && fp_wb_trans_id[0] == 3'd1) got_b.push_back(fp_wb_result[0]);
            acc1 = fu_valid[1] && fp_ready[1];
            if (k == 2) chk("bp_ready1_low", 64'(fp_ready[1]), 64'h0);
            tick();
            fu_valid[2] = 1'b0;
            fu_valid[3] = 1'b0;
            if (k + 1 < 5) set_ch(0, 64'hA0 + 64'(k + 1), 3'd0, 1'b0, 64'h0);
            else fu_valid[0] = 1'b0;
            if (acc1) begin
                b_idx++;
                if (b_idx < 3) set_ch(1, 64'hB1 + 64'(b_idx), 3'd1, 1'b0, 64'h0);
                else fu_valid[1] = 1'b0;
            end
        end
        chk("bp_count", 64'(got_b.size()), 64'h3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("bp_order%0d", i), (got_b.size() > i) ? got_b[i] : '1, 64'hB1 + 64'(i));

        // Flush with a non-zero pointer and a same-cycle push.
        do_reset();
        set_ch(2, 64'h22, 3'd2, 1'b0, 64'h0);
        tick();
        fu_valid = '0;
        set_ch(0, 64'hF0, 3'd0, 1'b0, 64'h0);
        set_ch(3, 64'hF3, 3'd3, 1'b0, 64'h0);
        @(negedge clk);
        chk("fl_pre_res", rr_wb_result[0], 64'h22);
        tick();
        fu_valid = '0;
        flush = 1'b1;
        set_ch(1, 64'hF1, 3'd1, 1'b0, 64'h0);
        @(negedge clk);
        chk("fl_rr_valid", 64'(rr_wb_valid), 64'h0);
        chk("fl_fp_valid", 64'(fp_wb_valid), 64'h0);
        tick();
        flush = 1'b0;
        fu_valid = '0;
        @(negedge clk);
        chk("fl_post_valid", 64'(rr_wb_valid), 64'h0);
        chk("fl_post_ready", 64'(rr_ready), 64'hF);
        tick();
        for (int c = 0; c < 4; c++) set_ch(c, 64'h300 + 64'(c), 3'(c), 1'b0, 64'h0);
        tick();
        fu_valid = '0;
        @(negedge clk);
        chk("fl_ptr_res0", rr_wb_result[0], 64'h300);
        chk("fl_ptr_res1", rr_wb_result[1], 64'h301);
        tick();

        // Fixed priority: ch0 keeps winning, queued exception on ch3 waits.
        do_reset();
        set_ch(3, 64'h33, 3'd3, 1'b1, 64'h2);
        set_ch(0, 64'hA00, 3'd0, 1'b0, 64'h0);
        tick();
        fu_valid[3] = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            set_ch(0, 64'hA00 + 64'(i), 3'd0, 1'b0, 64'h0);
            @(negedge clk);
            chk($sformatf("fp_ch0_res%0d", i), fp_wb_result[0], 64'hA00 + 64'(i - 1));
            chk($sformatf("fp_ch0_exv%0d", i), 64'(fp_wb_ex_valid[0]), 64'h0);
            tick();
        end
        fu_valid = '0;
        @(negedge clk);
        chk("fp_last_ch0", fp_wb_result[0], 64'hA04);
        tick();
        @(negedge clk);
        chk("fp_ex_valid", 64'(fp_wb_ex_valid[0]), 64'h1);
        chk("fp_ex_cause", fp_wb_ex_cause[0], 64'h2);
        chk("fp_ex_id", 64'(fp_wb_trans_id[0]), 64'h3);
        tick();

        // Randomised traffic with occasional flush and reset.
        do_reset();
        dens = 2;
        for (int n = 0; n < 3000; n++) begin
            if (n % 200 == 0) dens = $urandom_range(1, 3);
            rst   = ($urandom_range(0, 399) == 0);
            flush = ($urandom_range(0, 23) == 0);
            for (int c = 0; c < 4; c++) begin
                fu_valid[c]    = ($urandom_range(0, 3) < dens);
                fu_result[c]   = {$urandom, $urandom};
                fu_trans_id[c] = 3'($urandom_range(0, 7));
                fu_ex_valid[c] = ($urandom_range(0, 7) == 0);
                fu_ex_cause[c] = 64'($urandom_range(0, 15));
            end
            tick();
        end
        rst      = 1'b0;
        flush    = 1'b0;
        fu_valid = '0;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
